// File: rtl/divisor_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package divisor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/restador.sv
// Combinational WIDTH-bit subtractor; the trial-subtract stage of the divider.
module restador #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o
);

    assign diff_o = a_i - b_i;

endmodule

// File: rtl/divisor_seq.sv
// Restoring shift-subtract divider: one quotient bit per RUN cycle.
// Optional macro DIVISOR_DIV0_DETECT_EN short-circuits a zero divisor to DONE and flags it.
module divisor_seq
    import divisor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH:0]     a_sh;
    logic [WIDTH:0]     trial;
    logic               div0;

    // A < M always holds, so the shifted A fits in WIDTH+1 bits and so does the trial.
    assign a_sh = {a_q, mq_q[WIDTH-1]};

    restador #(.WIDTH(WIDTH + 1)) u_restador (
        .a_i    (a_sh),
        .b_i    ({1'b0, m_q}),
        .diff_o (trial)
    );

`ifdef DIVISOR_DIV0_DETECT_EN
    assign div0 = (m_q == '0);
`else
    assign div0 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        mq_d    = mq_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    mq_d    = dividend;
                    m_d     = divisor;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (div0) begin
                    // First RUN cycle: MQ still holds the untouched dividend.
                    a_d     = mq_q;
                    mq_d    = '1;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d   = trial[WIDTH] ? a_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            mq_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            mq_q    <= mq_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = mq_q;
    assign remainder   = a_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Scoreboard bench for divisor_seq: stimulus pushes expected results, a monitor checks each done.
module tb_divisor_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    divisor_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           at;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef DIVISOR_DIV0_DETECT_EN
    localparam bit DIV0_EN = 1'b1;
`else
    localparam bit DIV0_EN = 1'b0;
`endif

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_quot"}, 32'(quotient), 32'(e.q));
                check({e.tag, "_rem"}, 32'(remainder), 32'(e.r));
                check({e.tag, "_dbz"}, 32'(div_by_zero), 32'(e.z));
                check({e.tag, "_lat"}, cyc, e.at);
            end
        end
    end

    // Drives one request; lat counts edges from the sampling edge to the done edge inclusive.
    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                         input int lat, input bit push, input string tag);
        exp_t e;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.q = q; e.r = r; e.z = z; e.at = cyc + lat - 1; e.tag = tag;
            sb.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int c0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(8'd78, 8'd13, 8'd6, 8'd0, 1'b0, 9, 1'b1, "78/13");
        wait_done(30);
        repeat (3) @(negedge clk);
        check("hold_quot", 32'(quotient), 32'd6);
        check("hold_rem", 32'(remainder), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);

        issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 1'b1, "200/7");
        wait_done(30);
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, 1'b1, "255/1");
        wait_done(30);
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9, 1'b1, "5/9");
        wait_done(30);
        issue(8'd100, 8'd0, 8'd255, 8'd100, DIV0_EN, DIV0_EN ? 2 : 9, 1'b1, "100/0");
        wait_done(30);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, 1'b1, "9/3");
        wait_done(30);

        // Start pulses and operand churn while the division runs.
        issue(8'd78, 8'd13, 8'd6, 8'd0, 1'b0, 9, 1'b1, "noisy78/13");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start    = ~start;
            dividend = 8'd200 + 8'(i);
            divisor  = 8'd7 - 8'(i);
        end
        check("run_busy", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(30);
        repeat (12) @(negedge clk);

        // Reset during iteration 4 abandons the operation.
        issue(8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 9, 1'b0, "aborted");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quot", 32'(quotient), 32'd0);
        check("abort_rem", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        @(negedge clk);
        issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 1'b1, "post_rst200/7");
        wait_done(30);

        // Start held high: second operation accepted 10 edges after the first.
        @(negedge clk);
        dividend = 8'd78;
        divisor  = 8'd13;
        start    = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        sb.push_back('{q: 8'd6, r: 8'd0, z: 1'b0, at: c0 + 8, tag: "b2b_first"});
        sb.push_back('{q: 8'd6, r: 8'd0, z: 1'b0, at: c0 + 18, tag: "b2b_second"});
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40);
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/divisor_seq.md
DIVISOR_SEQ -- requirements
Module: divisor_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured with start.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured with start.
REQ-007 SHALL have port busy, output, 1 bit: high while not in IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the results become valid.
REQ-009 SHALL have port quotient, output, WIDTH bits: the MQ register.
REQ-010 SHALL have port remainder, output, WIDTH bits: the A register.
REQ-011 SHALL have port div_by_zero, output, 1 bit: flag for a divisor of zero.

Function
REQ-012 SHALL implement restoring shift-subtract division, the inverse of the team's shift-add multiplier, using registers A (remainder), MQ (quotient) and M (divisor).
REQ-013 SHALL use a state machine with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, load A=0, MQ=dividend, M=divisor and count=0, then go to RUN.
REQ-015 SHALL, in each RUN cycle, shift {A,MQ} left by 1, form trial = A_shifted - M at WIDTH+1 bits, and then apply REQ-016 or REQ-017.
REQ-016 SHALL, if trial is non-negative (MSB=0), set A=trial[WIDTH-1:0] and MQ[0]=1.
REQ-017 SHALL, if trial is negative, keep A=A_shifted and set MQ[0]=0.
REQ-018 SHALL go from RUN to DONE after exactly WIDTH iterations, tracking them with a counter wide enough for WIDTH.
REQ-019 SHALL, in DONE, assert done for exactly one cycle and return to IDLE on the next edge.
REQ-020 SHALL have a latency of WIDTH+1 clock edges from the start-sampling edge to the edge that asserts done.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable from done until the next accepted start.
REQ-022 SHALL ignore start while busy=1, with no effect on the operation in progress.
REQ-023 SHALL, if start is held high continuously, begin a new operation on the first IDLE cycle after DONE.
REQ-024 SHALL ignore changes to dividend or divisor after the capture edge.
REQ-025 SHALL give results satisfying dividend = quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.

Reset
REQ-026 SHALL, while rst_n=0 and regardless of clk, force state=IDLE and busy=0.
REQ-027 SHALL, under the same reset, force done=0, div_by_zero=0, quotient=0, remainder=0, M=0 and count=0.
REQ-028 SHALL, when reset is asserted mid-operation, abandon the division and produce no done pulse.
REQ-029 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, when macro DIVISOR_DIV0_DETECT_EN is defined and start is accepted with divisor=0, go directly to DONE on the next edge.
REQ-031 SHALL, in that case, produce quotient = all ones, remainder = dividend and div_by_zero=1, with done after 2 edges.
REQ-032 SHALL, without DIVISOR_DIV0_DETECT_EN, run the full WIDTH iterations for divisor=0.
REQ-033 SHALL, in that case, naturally yield quotient = all ones and remainder = dividend, with div_by_zero tied to 0.
REQ-034 SHALL have div_by_zero=0 after every division with a nonzero divisor.

Structure
REQ-035 SHALL put the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant in a shared package, divisor_pkg.
REQ-036 SHALL implement the WIDTH+1-bit trial subtraction in one combinational sub-module named restador, the subtract counterpart of sumador.
REQ-037 SHALL keep all registers and the state machine in divisor_seq.

Verification
REQ-038 SHALL verify 78/13: quotient=6, remainder=0, with done exactly 9 edges after start.
REQ-039 SHALL verify 200/7 -> quotient=28, remainder=4; 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5.
REQ-040 SHALL verify 100/0: quotient=255, remainder=100, div_by_zero=1 (done after 2 edges) with the macro; div_by_zero=0 (done after 9 edges) without it.
REQ-041 SHALL verify that start pulses and operand changes during RUN leave the results of 78/13 unchanged, with a single done pulse.
REQ-042 SHALL verify that rst_n low during iteration 4 gives all outputs 0 and no done, and that a following 200/7 completes correctly.
REQ-043 SHALL verify that start held high across two back-to-back operations gives two done pulses 10 edges apart.
